// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared codes and helpers for the ex_stage_md execute stage
// Contents: ALU opcodes, forwarding selects, destination selects,
// control-bundle bit indices, mul/div FSM state type, opcode classifiers.
package ex_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_MFLO = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1110;
    localparam logic [3:0] ALU_MFHI = 4'b1111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    localparam logic [1:0] RDST_RT   = 2'b00;
    localparam logic [1:0] RDST_RD   = 2'b01;
    localparam logic [1:0] RDST_LINK = 2'b10;

    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMREAD  = 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    // Ops that start the multiply/divide unit.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

    // Ops that must wait until HI/LO is settled.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV) || (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative signed multiply/divide unit owning HI/LO
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_start         launch an operation (only honoured in IDLE)
//   i_is_div        1 = divide, 0 = multiply
//   i_a, i_b        signed operands (dividend/divisor or factors)
//   o_busy          unit is not IDLE; HI/LO not yet final
//   o_hi, o_lo      HI/LO architectural registers
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    md_state_t           r_state;
    md_state_t           w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mag_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits becoming quotient}.
    logic [2*DATA_W-1:0] r_acc;
    logic                r_is_div;
    logic                r_neg_lo;
    logic                r_neg_hi;
    logic                r_div0;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_diff;
    logic [2*DATA_W-1:0] w_acc_step;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_mag_a = i_a[DATA_W-1] ? -i_a : i_a;
    assign w_mag_b = i_b[DATA_W-1] ? -i_b : i_b;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
        w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
        w_div_diff  = w_div_shift - {1'b0, r_mag_b};
        if (r_is_div) begin
            // Borrow in the top bit means the trial subtract failed: restore.
            if (!w_div_diff[DATA_W]) begin
                w_acc_step = {w_div_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_step = {w_div_shift[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_acc_step = {w_mul_sum, r_acc[DATA_W-1:1]};
        end
    end

    assign w_prod = r_neg_lo ? -r_acc : r_acc;
    assign w_quo  = r_neg_lo ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_hi ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_state_nxt = MD_RUN;
            MD_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mag_b  <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_acc    <= {{DATA_W{1'b0}}, w_mag_a};
                        r_mag_b  <= w_mag_b;
                        r_is_div <= i_is_div;
                        r_neg_lo <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
                        r_neg_hi <= i_a[DATA_W-1];
                        r_div0   <= i_is_div && (i_b == '0);
                    end
                end
                MD_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                MD_FIX: begin
                    if (r_is_div) begin
                        // A zero divisor leaves |dividend| as the remainder, so
                        // HI naturally becomes the dividend; only LO is forced.
                        r_lo <= r_div0 ? '1 : w_quo;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != MD_IDLE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - MIPS EX stage with forwarding, ALU, iterative mul/div and EX/MEM register
// Optional macro EX_OVERFLOW_TRAP_EN: ADD/SUB signed overflow drops regwrite
// and pulses the registered ovf_trap output.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid, control_in            ID/EX valid and control bundle
//   alu_src, alu_op, regdst         operand-B select, operation, destination select
//   pc_in, data1, data2, offset     PC+4, register reads, sign-extended immediate
//   rs/rt/rd_field                  register specifiers
//   ex_mem_data, wb_data            forwarding sources; forward_a/forward_b select them
//   stall_out                       hold upstream while HI/LO is pending
//   id_ex_regwrite/memread          gated control bits; rs_field_out passthrough
//   alu_data, rt, pc_out,
//   control_out, regdst_out         EX/MEM pipeline register
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RA_W       = 5,
    parameter int CTRL_W     = 14,
    parameter int CTRL_OUT_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [CTRL_W-1:0]     control_in,
    input  logic                  alu_src,
    input  logic [3:0]            alu_op,
    input  logic [1:0]            regdst,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     data1,
    input  logic [DATA_W-1:0]     data2,
    input  logic [DATA_W-1:0]     offset,
    input  logic [RA_W-1:0]       rs_field,
    input  logic [RA_W-1:0]       rt_field,
    input  logic [RA_W-1:0]       rd_field,
    input  logic [DATA_W-1:0]     ex_mem_data,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [1:0]            forward_a,
    input  logic [1:0]            forward_b,
    output logic                  stall_out,
    output logic                  id_ex_regwrite,
    output logic                  id_ex_memread,
    output logic [RA_W-1:0]       rs_field_out,
    output logic [DATA_W-1:0]     alu_data,
    output logic [DATA_W-1:0]     rt,
    output logic [DATA_W-1:0]     pc_out,
    output logic [CTRL_OUT_W-1:0] control_out,
    output logic [RA_W-1:0]       regdst_out
`ifdef EX_OVERFLOW_TRAP_EN
    ,
    output logic                  ovf_trap
`endif
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]     w_op_a;
    logic [DATA_W-1:0]     w_fwd_b;
    logic [DATA_W-1:0]     w_op_b;
    logic [DATA_W-1:0]     w_add;
    logic [DATA_W-1:0]     w_sub;
    logic [DATA_W-1:0]     w_alu_res;
    logic [DATA_W-1:0]     w_shamt_full;
    logic [SH_W-1:0]       w_shamt;
    logic [DATA_W-1:0]     w_hi;
    logic [DATA_W-1:0]     w_lo;
    logic                  w_busy;
    logic                  w_md_start;
    logic                  w_bubble;
    logic                  w_ovf;
    logic [RA_W-1:0]       w_dest;
    logic [CTRL_OUT_W-1:0] w_ctrl_nxt;
    logic                  w_unused;

    logic [DATA_W-1:0]     r_alu_data;
    logic [DATA_W-1:0]     r_rt;
    logic [DATA_W-1:0]     r_pc;
    logic [CTRL_OUT_W-1:0] r_ctrl;
    logic [RA_W-1:0]       r_regdst;

    always_comb begin
        case (forward_a)
            FWD_EXMEM: w_op_a = ex_mem_data;
            FWD_WB:    w_op_a = wb_data;
            default:   w_op_a = data1;
        endcase
        case (forward_b)
            FWD_EXMEM: w_fwd_b = ex_mem_data;
            FWD_WB:    w_fwd_b = wb_data;
            default:   w_fwd_b = data2;
        endcase
    end

    assign w_op_b       = alu_src ? offset : w_fwd_b;
    assign w_shamt_full = offset >> 6;
    assign w_shamt      = w_shamt_full[SH_W-1:0];
    assign w_add        = w_op_a + w_op_b;
    assign w_sub        = w_op_a - w_op_b;
    assign w_ovf        = ((alu_op == ALU_ADD) && (w_op_a[DATA_W-1] == w_op_b[DATA_W-1])
                                               && (w_add[DATA_W-1] != w_op_a[DATA_W-1]))
                       || ((alu_op == ALU_SUB) && (w_op_a[DATA_W-1] != w_op_b[DATA_W-1])
                                               && (w_sub[DATA_W-1] != w_op_a[DATA_W-1]));

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_ADD:  w_alu_res = w_add;
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_NOR:  w_alu_res = ~(w_op_a | w_op_b);
            ALU_MFLO: w_alu_res = w_lo;
            ALU_SUB:  w_alu_res = w_sub;
            ALU_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (w_op_a < w_op_b)};
            ALU_SLL:  w_alu_res = w_op_b << w_shamt;
            ALU_SRL:  w_alu_res = w_op_b >> w_shamt;
            ALU_SRA:  w_alu_res = $signed(w_op_b) >>> w_shamt;
            ALU_LUI:  w_alu_res = w_op_b << (DATA_W / 2);
            ALU_MFHI: w_alu_res = w_hi;
            default:  w_alu_res = '0;   // MULT/DIV only touch HI/LO
        endcase
    end

    always_comb begin
        case (regdst)
            RDST_RD:   w_dest = rd_field;
            RDST_LINK: w_dest = '1;
            default:   w_dest = rt_field;
        endcase
    end

    assign stall_out  = in_valid & is_hilo_op(alu_op) & w_busy;
    assign w_md_start = in_valid & is_md_op(alu_op) & ~w_busy;
    assign w_bubble   = ~in_valid | stall_out;

    always_comb begin
        w_ctrl_nxt = control_in[CTRL_OUT_W-1:0];
        if (w_bubble || is_md_op(alu_op)) begin
            w_ctrl_nxt = '0;
        end
`ifdef EX_OVERFLOW_TRAP_EN
        if (w_ovf) begin
            w_ctrl_nxt[CTL_REGWRITE] = 1'b0;
        end
`endif
    end

    muldiv_iter #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_md_start),
        .i_is_div (alu_op == ALU_DIV),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_busy   (w_busy),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_data <= '0;
            r_rt       <= '0;
            r_pc       <= '0;
            r_ctrl     <= '0;
            r_regdst   <= '0;
        end else begin
            r_alu_data <= w_alu_res;
            r_rt       <= w_fwd_b;
            r_pc       <= pc_in;
            r_ctrl     <= w_ctrl_nxt;
            r_regdst   <= w_bubble ? '0 : w_dest;
        end
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic r_ovf_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_trap <= 1'b0;
        end else begin
            r_ovf_trap <= ~w_bubble & w_ovf;
        end
    end

    assign ovf_trap = r_ovf_trap;
`endif

    // Upper control bits stop at EX; wrapping overflow is silent without the trap.
    assign w_unused = ^{control_in[CTRL_W-1:CTRL_OUT_W], w_shamt_full[DATA_W-1:SH_W], w_ovf};

    assign id_ex_regwrite = in_valid & control_in[CTL_REGWRITE];
    assign id_ex_memread  = in_valid & control_in[CTL_MEMREAD];
    assign rs_field_out   = rs_field;
    assign alu_data       = r_alu_data;
    assign rt             = r_rt;
    assign pc_out         = r_pc;
    assign control_out    = r_ctrl;
    assign regdst_out     = r_regdst;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - self-checking bench for ex_stage_md
module tb_ex_stage_md;
    import ex_pkg::*;

    localparam logic [13:0] CTL = 14'h3055;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] control_in = '0;
    logic        alu_src = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [1:0]  regdst = '0;
    logic [31:0] pc_in = '0, data1 = '0, data2 = '0, offset = '0;
    logic [4:0]  rs_field = '0, rt_field = '0, rd_field = '0;
    logic [31:0] ex_mem_data = '0, wb_data = '0;
    logic [1:0]  forward_a = '0, forward_b = '0;
    logic        stall_out, id_ex_regwrite, id_ex_memread;
    logic [4:0]  rs_field_out, regdst_out;
    logic [31:0] alu_data, rt, pc_out;
    logic [6:0]  control_out;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        ovf_trap;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    ex_stage_md dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .control_in(control_in),
        .alu_src(alu_src), .alu_op(alu_op), .regdst(regdst), .pc_in(pc_in),
        .data1(data1), .data2(data2), .offset(offset), .rs_field(rs_field),
        .rt_field(rt_field), .rd_field(rd_field), .ex_mem_data(ex_mem_data),
        .wb_data(wb_data), .forward_a(forward_a), .forward_b(forward_b),
        .stall_out(stall_out), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .rs_field_out(rs_field_out),
        .alu_data(alu_data), .rt(rt), .pc_out(pc_out),
        .control_out(control_out), .regdst_out(regdst_out)
`ifdef EX_OVERFLOW_TRAP_EN
        , .ovf_trap(ovf_trap)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; control_in = CTL; alu_src = 1'b0; alu_op = op;
        data1 = a; data2 = b; forward_a = FWD_REG; forward_b = FWD_REG;
        regdst = RDST_RD; rd_field = 5'd3;
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] e, input logic [31:0] w);
        if (sel == 2'b01) return e;
        if (sel == 2'b10) return w;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
        int sa, sb;
        sa = a; sb = b;
        case (op)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_MFLO: return m_lo;
            ALU_SUB:  return a - b;
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return b * (32'd1 << sh);
            ALU_SRL:  return b / (32'd1 << sh);
            ALU_SRA:  return sb >>> sh;
            ALU_LUI:  return b * 32'd65536;
            ALU_MFHI: return m_hi;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic void md_ref(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] lo,
                                   output logic [31:0] hi);
        longint la, lb, p, q, r;
        la = longint'($signed(a)); lb = longint'($signed(b));
        if (op == ALU_MULT) begin
            p = la * lb; hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else begin
            q = la / lb; r = la % lb; lo = q[31:0]; hi = r[31:0];
        end
    endfunction

    // Issue MULT/DIV, then an MFLO that waits out the stall, then MFHI.
    task automatic md_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic [31:0] hi, output int stalls);
        set_op(op, a, b);
        #1 check("md_issue_nostall", stall_out, 0);
        tick();
        check("md_ctrl_zero", control_out, 0);
        md_ref(op, a, b, m_lo, m_hi);
        alu_op = ALU_MFLO;
        stalls = 0;
        #1;
        while (stall_out === 1'b1 && stalls < 100) begin
            tick();
            stalls++;
        end
        check("stall_bubble_ctrl", control_out, 0);
        tick();
        lo = alu_data;
        check("mflo_ctrl", control_out, 7'h55);
        alu_op = ALU_MFHI;
        tick();
        hi = alu_data;
    endtask

    initial begin
        logic [31:0] lo, hi, a, b, bb, exp_alu;
        logic [6:0]  exp_ctl;
        logic [4:0]  exp_dst;
        logic [3:0]  op;
        longint      s;
        int          n;
        bit          ovf;

        repeat (2) tick();
        check("rst_alu", alu_data, 0);
        check("rst_ctl", control_out, 0);
        check("rst_dst", regdst_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_stall", stall_out, 0);
        rst_n = 1'b1;

        set_op(ALU_ADD, 32'hdead, 32'd7);
        forward_a = FWD_EXMEM; ex_mem_data = 32'd5; rd_field = 5'd9; pc_in = 32'h100;
        rs_field = 5'd17;
        #1;
        check("id_ex_regwrite", id_ex_regwrite, 1);
        check("rs_passthru", rs_field_out, 17);
        tick();
        check("add_fwd", alu_data, 12);
        check("add_dst", regdst_out, 9);
        check("add_pc", pc_out, 32'h100);
        check("add_rt", rt, 7);
        check("add_ctl", control_out, 7'h55);

        set_op(ALU_SRA, 32'd0, 32'h8000_0000);
        offset = 32'd4 << 6;
        tick();
        check("sra", alu_data, 32'hF800_0000);
        set_op(ALU_LUI, 32'd0, 32'd0);
        alu_src = 1'b1; offset = 32'h0000_1234; regdst = RDST_LINK;
        tick();
        check("lui", alu_data, 32'h1234_0000);
        check("link_dst", regdst_out, 5'h1f);

        md_run(ALU_MULT, 32'hFFFF_FFFA, 32'd7, lo, hi, n);
        check("mult_stalls", n, 33);
        check("mult_lo", lo, 32'hFFFF_FFD6);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        md_run(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lo, hi, n);
        check("div_stalls", n, 33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        md_run(ALU_DIV, 32'd9, 32'd0, lo, hi, n);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd9);

        for (int i = 0; i < 6; i++) begin
            op = (i % 2 == 0) ? ALU_MULT : ALU_DIV;
            a = $urandom;
            b = (i == 3) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1));
            md_run(op, a, b, lo, hi, n);
            check("rnd_md_stalls", n, 33);
            check("rnd_md_lo", lo, m_lo);
            check("rnd_md_hi", hi, m_hi);
        end

        // Non-MD work proceeds while the unit is busy.
        set_op(ALU_MULT, 32'd3, 32'd5);
        tick();
        set_op(ALU_ADD, 32'd3, 32'd4);
        #1 check("busy_add_nostall", stall_out, 0);
        tick();
        check("busy_add", alu_data, 7);
        check("busy_add_ctl", control_out, 7'h55);
        alu_op = ALU_MFLO;
        n = 0;
        #1;
        while (stall_out === 1'b1 && n < 100) begin tick(); n++; end
        check("busy_stalls", n, 32);
        tick();
        check("busy_mflo", alu_data, 15);
        m_lo = 32'd15; m_hi = 32'd0;

        // Invalid slot: no start, bubble into EX/MEM.
        set_op(ALU_MULT, 32'd5, 32'd5);
        in_valid = 1'b0;
        #1 check("inv_regwrite", id_ex_regwrite, 0);
        tick();
        check("inv_ctl", control_out, 0);
        check("inv_dst", regdst_out, 0);
        set_op(ALU_MFLO, 32'd0, 32'd0);
        #1 check("inv_no_start", stall_out, 0);
        tick();
        check("inv_lo_kept", alu_data, 15);

        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        tick();
        check("ovf_wrap", alu_data, 32'h8000_0000);
`ifdef EX_OVERFLOW_TRAP_EN
        check("ovf_trap", ovf_trap, 1);
        check("ovf_regwrite", control_out[0], 0);
        set_op(ALU_ADD, 32'd1, 32'd1);
        tick();
        check("ovf_trap_clear", ovf_trap, 0);
`else
        check("ovf_regwrite", control_out[0], 1);
`endif

        for (int i = 0; i < 60; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op == ALU_MULT || op == ALU_DIV);
            in_valid = ($urandom_range(0, 7) != 0);
            control_in = 14'($urandom); alu_op = op; alu_src = 1'($urandom_range(0, 1));
            regdst = 2'($urandom_range(0, 3)); rt_field = 5'($urandom); rd_field = 5'($urandom);
            data1 = $urandom; data2 = $urandom; ex_mem_data = $urandom; wb_data = $urandom;
            offset = $urandom; pc_in = $urandom;
            forward_a = 2'($urandom_range(0, 3)); forward_b = 2'($urandom_range(0, 3));
            a = fwd(forward_a, data1, ex_mem_data, wb_data);
            bb = fwd(forward_b, data2, ex_mem_data, wb_data);
            b = alu_src ? offset : bb;
            exp_alu = alu_ref(op, a, b, int'(offset[10:6]));
            s = (op == ALU_SUB) ? longint'($signed(a)) - longint'($signed(b))
                                : longint'($signed(a)) + longint'($signed(b));
            ovf = (op == ALU_ADD || op == ALU_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            exp_ctl = in_valid ? control_in[6:0] : 7'd0;
`ifdef EX_OVERFLOW_TRAP_EN
            if (ovf) exp_ctl[0] = 1'b0;
`endif
            exp_dst = !in_valid ? 5'd0 : (regdst == 2'b01) ? rd_field : (regdst == 2'b10) ? 5'h1f : rt_field;
            #1;
            check("rnd_regwrite", id_ex_regwrite, in_valid & control_in[0]);
            check("rnd_memread", id_ex_memread, in_valid & control_in[1]);
            check("rnd_stall", stall_out, 0);
            tick();
            if (in_valid) begin
                check("rnd_alu", alu_data, exp_alu);
                check("rnd_rt", rt, bb);
            end
            check("rnd_ctl", control_out, exp_ctl);
            check("rnd_dst", regdst_out, exp_dst);
`ifdef EX_OVERFLOW_TRAP_EN
            check("rnd_ovf", ovf_trap, in_valid & ovf);
`endif
        end

        // Reset in the middle of a DIV.
        set_op(ALU_DIV, 32'd100, 32'd3);
        tick();
        set_op(ALU_ADD, 32'd3, 32'd4);
        repeat (8) tick();
        alu_op = ALU_MFLO;
        #1;
        check("pre_rst_stall", stall_out, 1);
        check("pre_rst_alu", alu_data, 7);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", stall_out, 0);
        check("rst_mid_alu", alu_data, 0);
        check("rst_mid_ctl", control_out, 0);
        tick();
        rst_n = 1'b1;
        #1 check("post_rst_nostall", stall_out, 0);
        tick();
        check("post_rst_lo", alu_data, 0);
        alu_op = ALU_MFHI;
        tick();
        check("post_rst_hi", alu_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
